// File: rtl/serial_nibble_rx_if.sv
// Serial nibble receiver bus: serial input side plus the FIFO read side.
interface serial_nibble_rx_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          enb;
  logic          s_in;
  logic          dir;
  logic          ready;
  logic [3:0]    q;
  logic          valid;
  logic          par_err;
  logic          frm_err;
  logic          overrun;
  logic [CW-1:0] count;

  modport master (
    output enb, s_in, dir, ready,
    input  q, valid, par_err, frm_err, overrun, count
  );

  modport slave (
    input  enb, s_in, dir, ready,
    output q, valid, par_err, frm_err, overrun, count
  );
endinterface

// File: rtl/serial_nibble_rx.sv
// Serial nibble receiver: start(1), 4 data bits, optional even parity, stop(0).
// Received words go into a small FIFO with parity flag, overrun and framing status.
module serial_nibble_rx #(
  parameter int PARITY_EN = 1,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_nibble_rx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic [1:0]    bit_cnt;
  logic [3:0]    shreg;
  logic          dir_lat;
  logic          perr;
  logic          push_req;
  logic          frm_set;
  logic          frm_q;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovr;
  logic          valid;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; only edges with enb set advance the frame
  always_comb begin
    state_nx = state;
    push_req = 1'b0;
    frm_set  = 1'b0;
    if (bus.enb) begin
      case (state)
        IDLE:    if (bus.s_in) state_nx = DATA;
        DATA:    if (bit_cnt == 2'd3) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:  state_nx = STOP;
        STOP: begin
          state_nx = IDLE;
          if (bus.s_in) frm_set  = 1'b1;
          else          push_req = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Bit counter, shift data, latched bit order and parity result
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      dir_lat <= 1'b0;
      perr    <= 1'b0;
    end else if (bus.enb) begin
      case (state)
        IDLE: if (bus.s_in) begin
          bit_cnt <= '0;
          dir_lat <= bus.dir;
          perr    <= 1'b0;
        end
        DATA: begin
          bit_cnt <= bit_cnt + 2'd1;
          shreg   <= dir_lat ? {bus.s_in, shreg[3:1]} : {shreg[2:0], bus.s_in};
        end
        PARITY:  perr <= (^shreg) ^ bus.s_in;
        default: ;
      endcase
    end
  end

  // Framing error pulse: high only for the cycle after a bad stop sample
  always_ff @(posedge clk) begin
    if (rst) frm_q <= 1'b0;
    else     frm_q <= frm_set;
  end

  assign valid = (cnt != '0);
  assign full  = (cnt == CW'(DEPTH));
  assign pop   = valid && bus.ready;
  // When full, a simultaneous pop frees the slot being written (wr_ptr == rd_ptr)
  assign wr_en = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  // FIFO pointers, occupancy and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (drop)  ovr    <= 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // FIFO storage: {data, parity error}
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= {shreg, perr};
  end

  assign bus.valid   = valid;
  assign bus.q       = valid ? mem[rd_ptr][4:1] : '0;
  assign bus.par_err = valid ? mem[rd_ptr][0]   : 1'b0;
  assign bus.count   = cnt;
  assign bus.overrun = ovr;
  assign bus.frm_err = frm_q;
endmodule
